// File: rtl/ram_pkg.sv
// Shared types and default constants for the latency_ram data memory model.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    localparam int WORD_W        = 32;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_READ_LAT  = 3;
    localparam int DEF_WRITE_LAT = 2;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-index storage: registered read data, write on enable.
import ram_pkg::*;

module ram_array #(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/latency_ram.sv
// Fixed-latency word RAM behind an active-low nRD/nWR strobe interface.
// Optional RAM_ALIGN_CHECK_EN adds a misalign flag and suppresses unaligned accesses.
import ram_pkg::*;

module latency_ram #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address,
    input  logic [WORD_W-1:0] writeData,
    input  logic              nRD,
    input  logic              nWR,
    output logic [WORD_W-1:0] Dataout,
    output logic              readStatus,
    output logic              writeStatus,
`ifdef RAM_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              busy
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                bad_q, bad_d;
    logic                rd_status_q, rd_status_d;
    logic                wr_status_q, wr_status_d;
    logic                misalign_q, misalign_d;
    logic                mem_re, mem_we;
    logic                addr_bad;

`ifdef RAM_ALIGN_CHECK_EN
    logic unused_addr;
    assign addr_bad    = |address[1:0];
    assign unused_addr = ^address[31:ADDR_W+2];
    assign misalign    = misalign_q;
`else
    logic unused_addr;
    assign addr_bad    = 1'b0;
    assign unused_addr = ^{address[31:ADDR_W+2], address[1:0], misalign_q};
`endif

    // Read wins when both strobes arrive together; strobes are ignored outside IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        bad_d       = bad_q;
        rd_status_d = 1'b0;
        wr_status_d = 1'b0;
        misalign_d  = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!nRD) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    idx_d   = address[ADDR_W+1:2];
                    bad_d   = addr_bad;
                end else if (!nWR) begin
                    state_d = WR_WAIT;
                    cnt_d   = CNT_W'(WRITE_LAT - 1);
                    idx_d   = address[ADDR_W+1:2];
                    wdata_d = writeData;
                    bad_d   = addr_bad;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    rd_status_d = 1'b1;
                    misalign_d  = bad_q;
                    mem_re      = !bad_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    wr_status_d = 1'b1;
                    misalign_d  = bad_q;
                    mem_we      = !bad_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            bad_q       <= 1'b0;
            rd_status_q <= 1'b0;
            wr_status_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            bad_q       <= bad_d;
            rd_status_q <= rd_status_d;
            wr_status_q <= wr_status_d;
            misalign_q  <= misalign_d;
        end
    end

    // Reset on the commit edge must abort the pending write.
    ram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we && !rst),
        .re      (mem_re && !rst),
        .idx     (idx_q),
        .wdata   (wdata_q),
        .rd_data (Dataout)
    );

    assign readStatus  = rd_status_q;
    assign writeStatus = wr_status_q;
    assign busy        = (state_q != IDLE) || rd_status_q || wr_status_q;

endmodule

// File: tb/tb_latency_ram.sv
// Directed self-checking bench for latency_ram (default latencies: read 3, write 2).
module tb_latency_ram;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        nRD;
    logic        nWR;
    logic [31:0] Dataout;
    logic        readStatus;
    logic        writeStatus;
    logic        busy;
`ifdef RAM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    int          rd_k, wr_k, rd_cnt, wr_cnt, busy_cnt, overlap;
    logic [31:0] data_at_pulse;
    logic        mis_rd, mis_wr;

    latency_ram dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .writeData   (writeData),
        .nRD         (nRD),
        .nWR         (nWR),
        .Dataout     (Dataout),
        .readStatus  (readStatus),
        .writeStatus (writeStatus),
`ifdef RAM_ALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one strobe cycle at the current negedge, then observe 8 following negedges.
    task automatic do_access(input logic rd_n, input logic wr_n,
                             input logic [31:0] addr, input logic [31:0] data);
        nRD = rd_n; nWR = wr_n; address = addr; writeData = data;
        @(negedge clk);
        nRD = 1'b1; nWR = 1'b1;
        rd_k = 0; wr_k = 0; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; overlap = 0;
        mis_rd = 1'b0; mis_wr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (readStatus === 1'b1) begin
                rd_cnt++;
                if (rd_k == 0) rd_k = k;
                data_at_pulse = Dataout;
`ifdef RAM_ALIGN_CHECK_EN
                mis_rd = misalign;
`endif
            end
            if (writeStatus === 1'b1) begin
                wr_cnt++;
                if (wr_k == 0) wr_k = k;
`ifdef RAM_ALIGN_CHECK_EN
                mis_wr = misalign;
`endif
            end
            if (readStatus === 1'b1 && writeStatus === 1'b1) overlap++;
            if (busy === 1'b1) busy_cnt++;
            if (k < 8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; nRD = 1'b1; nWR = 1'b1; address = '0; writeData = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (Dataout !== 32'h0) begin failures++; $display("[TB] FAIL reset_dataout got=%h exp=%h", Dataout, 32'h0); end
        checks++; if (readStatus !== 1'b0) begin failures++; $display("[TB] FAIL reset_readStatus got=%b exp=0", readStatus); end
        checks++; if (writeStatus !== 1'b0) begin failures++; $display("[TB] FAIL reset_writeStatus got=%b exp=0", writeStatus); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
`ifdef RAM_ALIGN_CHECK_EN
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign); end
`endif
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (wr_k != 3) begin failures++; $display("[TB] FAIL wr_latency got=%0d exp=3", wr_k); end
        checks++; if (wr_cnt != 1) begin failures++; $display("[TB] FAIL wr_pulse_count got=%0d exp=1", wr_cnt); end
        checks++; if (rd_cnt != 0) begin failures++; $display("[TB] FAIL wr_no_read got=%0d exp=0", rd_cnt); end
        checks++; if (busy_cnt != 3) begin failures++; $display("[TB] FAIL wr_busy_cycles got=%0d exp=3", busy_cnt); end
        do_access(1'b0, 1'b1, 32'h10, 32'h0);
        checks++; if (rd_k != 4) begin failures++; $display("[TB] FAIL rd_latency got=%0d exp=4", rd_k); end
        checks++; if (rd_cnt != 1) begin failures++; $display("[TB] FAIL rd_pulse_count got=%0d exp=1", rd_cnt); end
        checks++; if (data_at_pulse !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data got=%h exp=%h", data_at_pulse, 32'hDEADBEEF); end
        checks++; if (Dataout !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data_hold got=%h exp=%h", Dataout, 32'hDEADBEEF); end
`ifdef RAM_ALIGN_CHECK_EN
        checks++; if (mis_rd !== 1'b0) begin failures++; $display("[TB] FAIL aligned_misalign got=%b exp=0", mis_rd); end
`endif
    endtask

    task automatic test_both_strobes();
        do_access(1'b1, 1'b0, 32'h20, 32'h11);
        do_access(1'b0, 1'b0, 32'h20, 32'h99);
        checks++; if (rd_cnt != 1) begin failures++; $display("[TB] FAIL both_read_pulse got=%0d exp=1", rd_cnt); end
        checks++; if (wr_cnt != 0) begin failures++; $display("[TB] FAIL both_write_dropped got=%0d exp=0", wr_cnt); end
        checks++; if (data_at_pulse !== 32'h11) begin failures++; $display("[TB] FAIL both_data got=%h exp=%h", data_at_pulse, 32'h11); end
        do_access(1'b0, 1'b1, 32'h20, 32'h0);
        checks++; if (data_at_pulse !== 32'h11) begin failures++; $display("[TB] FAIL both_mem_unchanged got=%h exp=%h", data_at_pulse, 32'h11); end
    endtask

    task automatic test_wrap();
        do_access(1'b1, 1'b0, 32'h1000, 32'h5);
        checks++; if (wr_cnt != 1) begin failures++; $display("[TB] FAIL wrap_write got=%0d exp=1", wr_cnt); end
        do_access(1'b0, 1'b1, 32'h0, 32'h0);
        checks++; if (data_at_pulse !== 32'h5) begin failures++; $display("[TB] FAIL wrap_data got=%h exp=%h", data_at_pulse, 32'h5); end
    endtask

    // Second nRD pulse lands while the first read is still in flight.
    task automatic test_back_to_back();
        nRD = 1'b0; address = 32'h0;
        @(negedge clk);
        nRD = 1'b1;
        rd_cnt = 0; busy_cnt = 0; overlap = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) nRD = 1'b0;
            if (k == 3) nRD = 1'b1;
            if (readStatus === 1'b1) rd_cnt++;
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        checks++; if (rd_cnt != 1) begin failures++; $display("[TB] FAIL b2b_read_pulses got=%0d exp=1", rd_cnt); end
        checks++; if (busy_cnt != 4) begin failures++; $display("[TB] FAIL b2b_busy_cycles got=%0d exp=4", busy_cnt); end
        checks++; if (Dataout !== 32'h5) begin failures++; $display("[TB] FAIL b2b_data got=%h exp=%h", Dataout, 32'h5); end
    endtask

    // Reset lands on the edge that would commit the write.
    task automatic test_reset_mid_write();
        do_access(1'b1, 1'b0, 32'h40, 32'hAAAA);
        nWR = 1'b0; address = 32'h40; writeData = 32'hBBBB;
        @(negedge clk);
        nWR = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (writeStatus !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_writeStatus got=%b exp=0", writeStatus); end
        checks++; if (Dataout !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_dataout got=%h exp=%h", Dataout, 32'h0); end
        wr_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (writeStatus === 1'b1) wr_cnt++;
        end
        checks++; if (wr_cnt != 0) begin failures++; $display("[TB] FAIL rstmid_late_pulse got=%0d exp=0", wr_cnt); end
        do_access(1'b0, 1'b1, 32'h40, 32'h0);
        checks++; if (data_at_pulse !== 32'hAAAA) begin failures++; $display("[TB] FAIL rstmid_old_data got=%h exp=%h", data_at_pulse, 32'hAAAA); end
    endtask

`ifdef RAM_ALIGN_CHECK_EN
    task automatic test_misalign();
        do_access(1'b0, 1'b1, 32'h13, 32'h0);
        checks++; if (rd_cnt != 1) begin failures++; $display("[TB] FAIL mis_read_pulse got=%0d exp=1", rd_cnt); end
        checks++; if (mis_rd !== 1'b1) begin failures++; $display("[TB] FAIL mis_read_flag got=%b exp=1", mis_rd); end
        checks++; if (data_at_pulse !== 32'hAAAA) begin failures++; $display("[TB] FAIL mis_read_data got=%h exp=%h", data_at_pulse, 32'hAAAA); end
        do_access(1'b1, 1'b0, 32'h41, 32'hCC);
        checks++; if (wr_cnt != 1) begin failures++; $display("[TB] FAIL mis_write_pulse got=%0d exp=1", wr_cnt); end
        checks++; if (mis_wr !== 1'b1) begin failures++; $display("[TB] FAIL mis_write_flag got=%b exp=1", mis_wr); end
        do_access(1'b0, 1'b1, 32'h40, 32'h0);
        checks++; if (data_at_pulse !== 32'hAAAA) begin failures++; $display("[TB] FAIL mis_write_blocked got=%h exp=%h", data_at_pulse, 32'hAAAA); end
        checks++; if (mis_rd !== 1'b0) begin failures++; $display("[TB] FAIL mis_clear got=%b exp=0", mis_rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_both_strobes();
        test_wrap();
        test_back_to_back();
        test_reset_mid_write();
`ifdef RAM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
